// File: rtl/pipe_core_pkg.sv
// Shared opcode encodings and instruction-field helpers for pipe_core.
package pipe_core_pkg;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_ADDI = 2'b01,
    OP_SUB  = 2'b10,
    OP_JMP  = 2'b11
  } opcode_e;

  // The all-zero word (ADD r0,r0) is the NOP and never writes back.
  localparam int unsigned NOP_INSTR = 0;

  function automatic int unsigned instr_w(int unsigned ra_w);
    return 2 + 2 * ra_w;
  endfunction

  function automatic int unsigned op_lsb(int unsigned ra_w);
    return 2 * ra_w;
  endfunction

  function automatic int unsigned rd_lsb(int unsigned ra_w);
    return ra_w;
  endfunction

  function automatic int unsigned off_w(int unsigned ra_w);
    return 2 * ra_w;
  endfunction

endpackage

// File: rtl/pipe_core_if.sv
// Instruction-memory, debug and retirement bus of pipe_core.
interface pipe_core_if
  import pipe_core_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RA_W   = 3,
  parameter int unsigned PC_W   = 5
);
  localparam int unsigned IW = instr_w(RA_W);

  logic              run;
  logic [PC_W-1:0]   imem_addr;
  logic [IW-1:0]     imem_data;
  logic [RA_W-1:0]   dbg_addr;
  logic [DATA_W-1:0] dbg_data;
  logic              wb_valid;
  logic [RA_W-1:0]   wb_addr;
  logic [DATA_W-1:0] wb_data;

  // Core side.
  modport master (
    input  run, imem_data, dbg_addr,
    output imem_addr, dbg_data, wb_valid, wb_addr, wb_data
  );

  // System / memory side.
  modport slave (
    output run, imem_data, dbg_addr,
    input  imem_addr, dbg_data, wb_valid, wb_addr, wb_data
  );
endinterface

// File: rtl/core_regfile.sv
// Register file: two write-through read ports, one raw debug port, one write port.
module core_regfile #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RA_W   = 3
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [RA_W-1:0]   waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [RA_W-1:0]   ra_addr_i,
  output logic [DATA_W-1:0] ra_data_o,
  input  logic [RA_W-1:0]   rb_addr_i,
  output logic [DATA_W-1:0] rb_data_o,
  input  logic [RA_W-1:0]   dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);
  localparam int unsigned NumRegs = 1 << RA_W;

  logic [DATA_W-1:0] mem_q [NumRegs];

  // Storage: synchronous clear, otherwise write when enabled.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
    end else if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Read ports: a same-cycle write to the same address is passed straight through.
  always_comb begin
    ra_data_o  = (we_i && (waddr_i == ra_addr_i)) ? wdata_i : mem_q[ra_addr_i];
    rb_data_o  = (we_i && (waddr_i == rb_addr_i)) ? wdata_i : mem_q[rb_addr_i];
    dbg_data_o = mem_q[dbg_addr_i];
  end

endmodule

// File: rtl/pipe_core.sv
// Three-stage (IF, ID, EX) accumulator-style core with forwarding and fetch-time jumps.
module pipe_core
  import pipe_core_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned RA_W   = 3,
  parameter int unsigned PC_W   = 5
) (
  input  logic       clk,
  input  logic       rst,
  pipe_core_if.master bus
);
  localparam int unsigned IW    = instr_w(RA_W);
  localparam int unsigned OpLsb = op_lsb(RA_W);
  localparam int unsigned RdLsb = rd_lsb(RA_W);
  localparam int unsigned OffW  = off_w(RA_W);

  // Fetch
  logic [PC_W-1:0] pc_q, pc_d;
  logic [IW-1:0]   ifid_q, ifid_d;
  opcode_e         fetch_op;
  logic            fetch_jmp;
  logic [PC_W-1:0] off_pc;

  // Decode -> execute
  logic              idex_valid_q, idex_valid_d;
  opcode_e           idex_op_q, idex_op_d;
  logic [RA_W-1:0]   idex_rd_q, idex_rd_d;
  logic [RA_W-1:0]   idex_rs_q, idex_rs_d;
  logic [DATA_W-1:0] idex_rdv_q, idex_rdv_d;
  logic [DATA_W-1:0] idex_rsv_q, idex_rsv_d;

  // Execute -> writeback
  logic              wb_valid_q, wb_valid_d;
  logic [RA_W-1:0]   wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  logic [DATA_W-1:0] rf_rd_data, rf_rs_data;
  logic              rf_we;
  logic [DATA_W-1:0] imm_ext, op_a, op_b;

  assign fetch_op  = opcode_e'(bus.imem_data[OpLsb +: 2]);
  assign fetch_jmp = (fetch_op == OP_JMP);

  // Jump offset resized to the PC width; the PC is modular so truncation is exact.
  if (PC_W > OffW) begin : g_off_sext
    assign off_pc = {{(PC_W - OffW){bus.imem_data[OffW-1]}}, bus.imem_data[OffW-1:0]};
  end else begin : g_off_trunc
    assign off_pc = bus.imem_data[PC_W-1:0];
  end

  // Immediate resized to the datapath width.
  if (DATA_W > RA_W) begin : g_imm_sext
    assign imm_ext = {{(DATA_W - RA_W){idex_rs_q[RA_W-1]}}, idex_rs_q};
  end else begin : g_imm_trunc
    assign imm_ext = idex_rs_q[DATA_W-1:0];
  end

  // IF: next PC and IF/ID; a JMP redirects immediately and enters IF/ID as a NOP.
  always_comb begin
    pc_d   = pc_q + PC_W'(1) + (fetch_jmp ? off_pc : '0);
    ifid_d = fetch_jmp ? IW'(NOP_INSTR) : bus.imem_data;
  end

  // ID: field decode and operand read; rd doubles as the left-hand operand.
  always_comb begin
    idex_valid_d = (ifid_q != IW'(NOP_INSTR));
    idex_op_d    = opcode_e'(ifid_q[OpLsb +: 2]);
    idex_rd_d    = ifid_q[RdLsb +: RA_W];
    idex_rs_d    = ifid_q[RA_W-1:0];
    idex_rdv_d   = rf_rd_data;
    idex_rsv_d   = rf_rs_data;
  end

  // EX: forward from EX/WB per operand, then the ALU.
  always_comb begin
    op_a = (wb_valid_q && (wb_addr_q == idex_rd_q)) ? wb_data_q : idex_rdv_q;
    op_b = (wb_valid_q && (wb_addr_q == idex_rs_q)) ? wb_data_q : idex_rsv_q;
    wb_valid_d = idex_valid_q;
    wb_addr_d  = idex_rd_q;
    unique case (idex_op_q)
      OP_ADD:  wb_data_d = op_a + op_b;
      OP_ADDI: wb_data_d = op_a + imm_ext;
      OP_SUB:  wb_data_d = op_a - op_b;
      default: wb_data_d = op_a; // JMP never reaches EX
    endcase
  end

  // Pipeline state: reset wins over run; run low freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q         <= '0;
      ifid_q       <= IW'(NOP_INSTR);
      idex_valid_q <= 1'b0;
      idex_op_q    <= OP_ADD;
      idex_rd_q    <= '0;
      idex_rs_q    <= '0;
      idex_rdv_q   <= '0;
      idex_rsv_q   <= '0;
      wb_valid_q   <= 1'b0;
      wb_addr_q    <= '0;
      wb_data_q    <= '0;
    end else if (bus.run) begin
      pc_q         <= pc_d;
      ifid_q       <= ifid_d;
      idex_valid_q <= idex_valid_d;
      idex_op_q    <= idex_op_d;
      idex_rd_q    <= idex_rd_d;
      idex_rs_q    <= idex_rs_d;
      idex_rdv_q   <= idex_rdv_d;
      idex_rsv_q   <= idex_rsv_d;
      wb_valid_q   <= wb_valid_d;
      wb_addr_q    <= wb_addr_d;
      wb_data_q    <= wb_data_d;
    end
  end

  // Writes retire only while the pipe advances.
  assign rf_we = wb_valid_q & bus.run;

  core_regfile #(
    .DATA_W(DATA_W),
    .RA_W  (RA_W)
  ) u_regfile (
    .clk_i     (clk),
    .rst_i     (rst),
    .we_i      (rf_we),
    .waddr_i   (wb_addr_q),
    .wdata_i   (wb_data_q),
    .ra_addr_i (ifid_q[RdLsb +: RA_W]),
    .ra_data_o (rf_rd_data),
    .rb_addr_i (ifid_q[RA_W-1:0]),
    .rb_data_o (rf_rs_data),
    .dbg_addr_i(bus.dbg_addr),
    .dbg_data_o(bus.dbg_data)
  );

  assign bus.imem_addr = pc_q;
  assign bus.wb_valid  = wb_valid_q;
  assign bus.wb_addr   = wb_addr_q;
  assign bus.wb_data   = wb_data_q;

endmodule

// File: tb/tb_pipe_core.sv
// Directed self-checking bench for pipe_core at default parameters.
module tb_pipe_core;
  logic clk;
  logic rst;
  logic [7:0] imem [32];
  int checks;
  int failures;

  pipe_core_if #(.DATA_W(8), .RA_W(3), .PC_W(5)) bus ();

  pipe_core #(.DATA_W(8), .RA_W(3), .PC_W(5)) u_dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  assign bus.imem_data = imem[bus.imem_addr];

  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reg(input string tag, input int idx, input logic [7:0] exp);
    bus.dbg_addr = 3'(idx);
    #1;
    check(tag, 32'(bus.dbg_data), 32'(exp));
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 32; i++) imem[i] = 8'h00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    bus.run = 1'b1;
    bus.dbg_addr = '0;
    clear_imem();

    // Reset state
    do_reset();
    check("rst_pc", 32'(bus.imem_addr), 32'd0);
    check("rst_wbv", 32'(bus.wb_valid), 32'd0);
    for (int i = 0; i < 8; i++) check_reg("rst_reg", i, 8'h00);

    // Back-to-back dependency: ADDI r1,3 x3
    clear_imem();
    imem[0] = 8'h4B; imem[1] = 8'h4B; imem[2] = 8'h4B;
    do_reset();
    step(); step(); step();
    check("b2b_v0", 32'(bus.wb_valid), 32'd1);
    check("b2b_a0", 32'(bus.wb_addr), 32'd1);
    check("b2b_d0", 32'(bus.wb_data), 32'd3);
    step();
    check("b2b_d1", 32'(bus.wb_data), 32'd6);
    step();
    check("b2b_d2", 32'(bus.wb_data), 32'd9);
    step();
    check("b2b_v3", 32'(bus.wb_valid), 32'd0);
    check_reg("b2b_r1", 1, 8'd9);

    // Freeze in the middle of the same program
    do_reset();
    step(); step(); step(); step();
    check("frz_pre_d", 32'(bus.wb_data), 32'd6);
    check_reg("frz_pre_r1", 1, 8'd3);
    bus.run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("frz_pc", 32'(bus.imem_addr), 32'd4);
      check("frz_wbv", 32'(bus.wb_valid), 32'd1);
      check("frz_wbd", 32'(bus.wb_data), 32'd6);
      check_reg("frz_r1", 1, 8'd3);
    end
    bus.run = 1'b1;
    step();
    check("frz_post_d", 32'(bus.wb_data), 32'd9);
    step();
    check("frz_post_v", 32'(bus.wb_valid), 32'd0);
    check_reg("frz_r1_fin", 1, 8'd9);

    // Reset with writes in flight
    do_reset();
    step(); step(); step(); step();
    check_reg("mid_pre_r1", 1, 8'd3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_wbv", 32'(bus.wb_valid), 32'd0);
    check("mid_pc", 32'(bus.imem_addr), 32'd0);
    for (int i = 0; i < 8; i++) check_reg("mid_reg", i, 8'h00);

    // Write-through: ADDI r1,3; NOP; ADD r2,r1
    clear_imem();
    imem[0] = 8'h4B; imem[1] = 8'h00; imem[2] = 8'h11;
    do_reset();
    step(); step(); step();
    check("wt_d0", 32'(bus.wb_data), 32'd3);
    step();
    check("wt_nop_v", 32'(bus.wb_valid), 32'd0);
    step();
    check("wt_v2", 32'(bus.wb_valid), 32'd1);
    check("wt_a2", 32'(bus.wb_addr), 32'd2);
    check("wt_d2", 32'(bus.wb_data), 32'd3);
    step();
    check_reg("wt_r2", 2, 8'd3);

    // Sign and wrap: ADDI r1,-1; SUB r2,r1
    clear_imem();
    imem[0] = 8'h4F; imem[1] = 8'h91;
    do_reset();
    step(); step(); step();
    check("sw_d0", 32'(bus.wb_data), 32'hFF);
    step();
    check("sw_d1", 32'(bus.wb_data), 32'h01);
    step();
    check_reg("sw_r1", 1, 8'hFF);
    check_reg("sw_r2", 2, 8'h01);

    // Jumps: forward skip and jump-to-self
    clear_imem();
    imem[0] = 8'hC2; imem[1] = 8'h4B; imem[2] = 8'h4B; imem[5] = 8'hFF;
    do_reset();
    check("jmp_pc0", 32'(bus.imem_addr), 32'd0);
    step();
    check("jmp_pc1", 32'(bus.imem_addr), 32'd3);
    step();
    check("jmp_pc2", 32'(bus.imem_addr), 32'd4);
    step();
    check("jmp_pc3", 32'(bus.imem_addr), 32'd5);
    check("jmp_wbv3", 32'(bus.wb_valid), 32'd0);
    step();
    check("jmp_self1", 32'(bus.imem_addr), 32'd5);
    check("jmp_wbv4", 32'(bus.wb_valid), 32'd0);
    step();
    check("jmp_self2", 32'(bus.imem_addr), 32'd5);
    check_reg("jmp_r1", 1, 8'h00);

    // PC wrap: jump to 31, then sequential fetch wraps to 0
    clear_imem();
    imem[0] = 8'hDE;
    do_reset();
    step();
    check("wrap_pc31", 32'(bus.imem_addr), 32'd31);
    step();
    check("wrap_pc0", 32'(bus.imem_addr), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
